// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the UART transmit port: register map, STATUS layout, FSM states.
package uart_tx_port_pkg;

  // Register addresses (Address[3:0])
  localparam logic [3:0] AddrTxData = 4'h0;
  localparam logic [3:0] AddrStatus = 4'h1;
  localparam logic [3:0] AddrPrescH = 4'h2;
  localparam logic [3:0] AddrPrescL = 4'h3;

  // STATUS bit positions
  localparam int unsigned StatusBusy  = 0;
  localparam int unsigned StatusFull  = 1;
  localparam int unsigned StatusEmpty = 2;
  localparam int unsigned StatusOvf   = 3;

  // Serializer states
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_port_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers so full/empty stay exact across wrap-around.
// A push while full is accepted only when a pop retires an entry in the same cycle.
module uart_tx_port_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q[AddrW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: bus registers, TX FIFO and baud-timed 8N1 serializer.
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter int unsigned FIFO_AW   = 3,
  parameter logic [15:0] PRESC_RST = 16'h0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Address,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       txd,
  output logic       tx_irq
);

  logic        wr_en, rd_en, push, status_rd, ovf_set;
  logic [15:0] presc_q;
  logic        ovf_q;
  logic [7:0]  rd_data;

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;

  assign wr_en     = cs & ~rw;
  assign rd_en     = cs & rw;
  assign push      = wr_en && (Address == AddrTxData);
  assign status_rd = rd_en && (Address == AddrStatus);
  // A same-cycle pop frees a slot, so only a push that really cannot land overflows
  assign ovf_set   = push & fifo_full & ~fifo_pop;
  assign tx_irq    = fifo_empty & (state_q == StIdle);

  uart_tx_port_sync_fifo #(
    .Width (8),
    .AddrW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fifo_pop),
    .wdata (DI),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Prescaler register writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= PRESC_RST;
    end else if (wr_en) begin
      if (Address == AddrPrescH) presc_q[15:8] <= DI;
      if (Address == AddrPrescL) presc_q[7:0]  <= DI;
    end
  end

  // Sticky overflow flag; a new overflow beats a coincident STATUS-read clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_set | (ovf_q & ~status_rd);
  end

  // Read data mux
  always_comb begin
    rd_data = 8'h00;
    case (Address)
      AddrStatus: begin
        rd_data[StatusOvf]   = ovf_q;
        rd_data[StatusEmpty] = fifo_empty;
        rd_data[StatusFull]  = fifo_full;
        rd_data[StatusBusy]  = (state_q != StIdle);
      end
      AddrPrescH: rd_data = presc_q[15:8];
      AddrPrescL: rd_data = presc_q[7:0];
      default:    rd_data = 8'h00;
    endcase
  end

  // Registered read port, holds when not read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       DO <= 8'h00;
    else if (rd_en) DO <= rd_data;
  end

  // Serializer state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // Serializer next state, FIFO pop and line level
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    fifo_pop = 1'b0;
    txd      = 1'b1;
    case (state_q)
      StIdle: begin
        if (!fifo_empty && (presc_q != 16'd0)) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          cnt_d    = presc_q;
          state_d  = StStart;
        end
      end
      StStart: begin
        txd = 1'b0;
        if (cnt_q == 16'd0) begin
          cnt_d   = presc_q;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        txd = shreg_q[0];
        if (cnt_q == 16'd0) begin
          cnt_d   = presc_q;
          shreg_d = {1'b0, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        txd = 1'b1;
        if (cnt_q == 16'd0) begin
          // Chain straight into the next frame when data is waiting
          if (!fifo_empty && (presc_q != 16'd0)) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_rdata;
            cnt_d    = presc_q;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: directed scenarios plus randomized frames.
module tb_uart_tx_port;

  localparam int Depth = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Address;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic       txd;
  logic       tx_irq;

  int vectors     = 0;
  int miscompares = 0;

  byte unsigned exp_q[$];
  byte unsigned wbytes[16];
  int           wcount;

  uart_tx_port #(
    .FIFO_AW   (3),
    .PRESC_RST (16'h0000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .Address (Address),
    .DI      (DI),
    .DO      (DO),
    .rw      (rw),
    .cs      (cs),
    .txd     (txd),
    .tx_irq  (tx_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] status_exp(input bit ovf, input int occ, input bit busy);
    return {4'b0000, ovf, (occ == 0), (occ == Depth), busy};
  endfunction

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    Address = a;
    DI      = d;
    rw      = 1'b0;
    cs      = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    rw = 1'b1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    Address = a;
    rw      = 1'b1;
    cs      = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    d  = DO;
  endtask

  // Checks one 8N1 frame cycle by cycle. Called at a negedge. With immediate set the start
  // bit must already be on the line. Optionally issues one bus write at (wr_bit, wr_cyc);
  // bits after wr_bit last pb+1 cycles, earlier bits pa+1.
  task automatic check_frame(input byte unsigned data, input int pa, input bit immediate,
                             input int wr_bit, input int wr_cyc, input logic [3:0] wr_addr,
                             input logic [7:0] wr_data, input int pb);
    int  n;
    int  len;
    bit  expbit;
    bit  inline_wr;
    n         = 0;
    inline_wr = 1'b0;
    if (!immediate) begin
      while (txd !== 1'b0 && n < 400) begin
        @(negedge clk);
        n++;
      end
    end
    chk("frame_start", txd, 0);
    for (int b = 0; b < 10; b++) begin
      len    = (wr_bit >= 0 && b > wr_bit) ? pb + 1 : pa + 1;
      expbit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : data[b-1];
      for (int c = 0; c < len; c++) begin
        if (inline_wr) begin
          cs        = 1'b0;
          rw        = 1'b1;
          inline_wr = 1'b0;
        end
        if (b == wr_bit && c == wr_cyc) begin
          Address   = wr_addr;
          DI        = wr_data;
          rw        = 1'b0;
          cs        = 1'b1;
          inline_wr = 1'b1;
        end
        chk("txd_bit", txd, expbit);
        chk("tx_irq_busy", tx_irq, 0);
        @(negedge clk);
      end
    end
    if (inline_wr) begin
      cs = 1'b0;
      rw = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] rd;
    int         occ;
    bit         ovf_m;
    int         p;
    int         n;

    rst     = 1'b0;
    cs      = 1'b0;
    rw      = 1'b1;
    Address = 4'h0;
    DI      = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_DO", DO, 8'h00);
    chk("reset_txd", txd, 1);
    chk("reset_irq", tx_irq, 1);
    rst = 1'b1;
    bus_read(4'h1, rd);
    chk("reset_status", rd, status_exp(0, 0, 0));
    bus_read(4'h2, rd);
    chk("reset_presc_h", rd, 8'h00);
    bus_read(4'h3, rd);
    chk("reset_presc_l", rd, 8'h00);

    // Single frame, 4 clk per bit
    bus_write(4'h2, 8'h00);
    bus_write(4'h3, 8'h03);
    bus_write(4'h0, 8'h55);
    check_frame(8'h55, 3, 0, -1, 0, 4'h0, 8'h00, 3);
    chk("irq_after_frame", tx_irq, 1);
    chk("txd_after_frame", txd, 1);

    // Halted transmitter: fill the FIFO, then overflow
    bus_write(4'h3, 8'h00);
    occ   = 0;
    ovf_m = 0;
    for (int i = 0; i < 8; i++) begin
      bus_write(4'h0, 8'(i));
      exp_q.push_back(8'(i));
      occ++;
      chk("halted_txd", txd, 1);
    end
    bus_read(4'h1, rd);
    chk("status_full", rd, status_exp(ovf_m, occ, 0));
    bus_write(4'h0, 8'h08);
    ovf_m = 1;
    bus_read(4'h1, rd);
    chk("status_ovf", rd, status_exp(ovf_m, occ, 0));
    ovf_m = 0;
    bus_read(4'h1, rd);
    chk("status_ovf_clr", rd, status_exp(ovf_m, occ, 0));
    bus_read(4'h0, rd);
    chk("txdata_reads_zero", rd, 8'h00);
    bus_read(4'h9, rd);
    chk("unmapped_reads_zero", rd, 8'h00);

    // Drain at 2 clk per bit; frames must follow each other with no idle gap
    bus_write(4'h3, 8'h01);
    check_frame(exp_q.pop_front(), 1, 0, -1, 0, 4'h0, 8'h00, 1);
    while (exp_q.size() > 0) check_frame(exp_q.pop_front(), 1, 1, -1, 0, 4'h0, 8'h00, 1);
    chk("drain_irq", tx_irq, 1);
    bus_read(4'h1, rd);
    chk("drain_status", rd, status_exp(0, 0, 0));

    // Prescaler change during DATA bit 2 applies from the next bit on
    bus_write(4'h3, 8'h03);
    wbytes[0] = 8'($urandom);
    bus_write(4'h0, wbytes[0]);
    check_frame(wbytes[0], 3, 0, 3, 0, 4'h3, 8'h07, 7);
    bus_read(4'h3, rd);
    chk("presc_readback", rd, 8'h07);

    // Push into a full FIFO on the STOP->START pop cycle is accepted without overflow
    bus_write(4'h3, 8'h03);
    for (int i = 0; i < 10; i++) begin
      wbytes[i] = 8'($urandom);
      exp_q.push_back(wbytes[i]);
    end
    fork
      check_frame(exp_q.pop_front(), 3, 0, 9, 3, 4'h0, wbytes[9], 3);
      begin
        for (int i = 0; i < 9; i++) bus_write(4'h0, wbytes[i]);
      end
    join
    while (exp_q.size() > 0) check_frame(exp_q.pop_front(), 3, 1, -1, 0, 4'h0, 8'h00, 3);
    bus_read(4'h1, rd);
    chk("full_push_pop_status", rd, status_exp(0, 0, 0));

    // Randomized bursts at random baud rates
    for (int r = 0; r < 6; r++) begin
      p      = int'($urandom_range(1, 5));
      wcount = int'($urandom_range(1, 4));
      bus_write(4'h2, 8'h00);
      bus_write(4'h3, 8'(p));
      for (int i = 0; i < wcount; i++) begin
        wbytes[i] = 8'($urandom);
        exp_q.push_back(wbytes[i]);
      end
      fork
        check_frame(exp_q.pop_front(), p, 0, -1, 0, 4'h0, 8'h00, p);
        begin
          for (int i = 0; i < wcount; i++) bus_write(4'h0, wbytes[i]);
        end
      join
      while (exp_q.size() > 0) check_frame(exp_q.pop_front(), p, 1, -1, 0, 4'h0, 8'h00, p);
      chk("rand_idle_irq", tx_irq, 1);
    end

    // Reset in the middle of DATA drops the frame
    bus_write(4'h3, 8'h03);
    bus_write(4'h0, 8'h00);
    n = 0;
    while (txd !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (13) @(negedge clk);
    chk("mid_data_txd", txd, 0);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_txd", txd, 1);
    chk("async_reset_irq", tx_irq, 1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      repeat (10) @(negedge clk);
      chk("post_reset_idle", txd, 1);
    end
    bus_read(4'h1, rd);
    chk("post_reset_status", rd, status_exp(0, 0, 0));
    bus_read(4'h2, rd);
    chk("post_reset_presc_h", rd, 8'h00);
    bus_read(4'h3, rd);
    chk("post_reset_presc_l", rd, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
